// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line types, arbiter state encoding and grant helper.
package lc3b_types;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned CLINE_W = 128;

  typedef logic [WORD_W-1:0]  lc3b_word;
  typedef logic [CLINE_W-1:0] lc3b_cline;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } mem_arb_grant_t;

  // D wins when it is the only requester, or when contested and preferred.
  function automatic logic arb_pick_d(input logic i_req, input logic d_req,
                                      input logic prefer_d);
    return d_req & (~i_req | prefer_d);
  endfunction

endpackage

// File: rtl/mem_arbiter_control.sv
// Arbiter FSM: grant decision, serve/recover sequencing and response strobes.
// MEM_ARBITER_FAIR_EN selects alternating priority on contested requests.
module mem_arbiter_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_read,
  input  logic d_read,
  input  logic d_write,
  input  logic pmem_resp,
  output logic grant_i,
  output logic grant_d,
  output logic serve_done,
  output logic i_resp,
  output logic d_resp
);

  mem_arb_state_t state_r;
  mem_arb_state_t state_next_s;
  logic           d_req_s;
  logic           prefer_d_s;

  assign d_req_s = d_read | d_write;

`ifdef MEM_ARBITER_FAIR_EN
  mem_arb_grant_t last_grant_r;

  // Remember which side won the most recent grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= GRANT_I;
    end else if (grant_d) begin
      last_grant_r <= GRANT_D;
    end else if (grant_i) begin
      last_grant_r <= GRANT_I;
    end
  end

  assign prefer_d_s = (last_grant_r == GRANT_I);
`else
  assign prefer_d_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and grant/response decode.
  always_comb begin
    state_next_s = state_r;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    serve_done   = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_read | d_req_s) begin
          if (arb_pick_d(i_read, d_req_s, prefer_d_s)) begin
            grant_d      = 1'b1;
            state_next_s = SERVE_D;
          end else begin
            grant_i      = 1'b1;
            state_next_s = SERVE_I;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_resp       = 1'b1;
          serve_done   = 1'b1;
          state_next_s = RECOVER;
        end else begin
          state_next_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_resp       = 1'b1;
          serve_done   = 1'b1;
          state_next_s = RECOVER;
        end else begin
          state_next_s = SERVE_D;
        end
      end
      // One dead cycle so a request still held after resp is not re-granted.
      RECOVER: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache to physical memory arbiter: request latches and pmem drive.
// Optional fair arbitration via MEM_ARBITER_FAIR_EN (see mem_arbiter_control).
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  logic              grant_i_s;
  logic              grant_d_s;
  logic              serve_done_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              pmem_read_r;
  logic              pmem_write_r;

  mem_arbiter_control u_control (
    .clk        (clk),
    .reset      (reset),
    .i_read     (i_read),
    .d_read     (d_read),
    .d_write    (d_write),
    .pmem_resp  (pmem_resp),
    .grant_i    (grant_i_s),
    .grant_d    (grant_d_s),
    .serve_done (serve_done_s),
    .i_resp     (i_resp),
    .d_resp     (d_resp)
  );

  // Capture the granted request; strobes stay up until the memory answers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {LINE_W{1'b0}};
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
    end else if (grant_d_s) begin
      addr_r       <= d_addr;
      wdata_r      <= d_wdata;
      pmem_write_r <= d_write;
      pmem_read_r  <= ~d_write;
    end else if (grant_i_s) begin
      addr_r       <= i_addr;
      pmem_read_r  <= 1'b1;
      pmem_write_r <= 1'b0;
    end else if (serve_done_s) begin
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
    end
  end

  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;

  // Read data fans out to both caches; each qualifies it with its own resp.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
